// File: rtl/ahb_slave_if.sv
// AHB-Lite responder for the AHB-to-APB bridge: decodes three 64 MB slots and hands
// each transfer to the back-end as a request/done handshake. Optional macro: AHB_SLV_TIMEOUT_EN.
module ahb_slave_if #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
`ifdef AHB_SLV_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        Hreadyout,
    output logic        be_valid,
    output logic        be_write,
    output logic [31:0] be_addr,
    output logic [31:0] be_wdata,
    output logic [2:0]  be_sel,
    input  logic        be_done,
    input  logic [31:0] be_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned SW = 3;
    localparam logic [AW-1:0] WIN_SIZE   = 32'h0C00_0000;
    localparam logic [1:0]    RESP_OKAY  = 2'b00;
    localparam logic [1:0]    RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_BUSY,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state;

    logic          accept_c;
    logic          mapped_c;
    logic [AW-1:0] offset_c;
    logic [SW-1:0] sel_c;

`ifdef AHB_SLV_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // Address-phase acceptance and slot decode
    always_comb begin
        accept_c = Hreadyin && Hreadyout && (Htrans == 2'b10 || Htrans == 2'b11);
        offset_c = Haddr - BASE_ADDR;
        mapped_c = offset_c < WIN_SIZE;
        sel_c    = '0;
        case (offset_c[27:26])
            2'd0:    sel_c = 3'b001;
            2'd1:    sel_c = 3'b010;
            2'd2:    sel_c = 3'b100;
            default: sel_c = 3'b000;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state     <= S_IDLE;
            Hreadyout <= 1'b1;
            Hresp     <= RESP_OKAY;
            Hrdata    <= '0;
            be_valid  <= 1'b0;
            be_write  <= 1'b0;
            be_addr   <= '0;
            be_wdata  <= '0;
            be_sel    <= '0;
`ifdef AHB_SLV_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                // ERR2 is the second ERROR cycle but accepts a new address like IDLE
                S_IDLE, S_ERR2: begin
                    state     <= S_IDLE;
                    Hreadyout <= 1'b1;
                    Hresp     <= RESP_OKAY;
                    if (accept_c) begin
                        Hreadyout <= 1'b0;
                        if (!mapped_c) begin
                            state <= S_ERR1;
                            Hresp <= RESP_ERROR;
                        end else begin
                            be_addr  <= Haddr;
                            be_sel   <= sel_c;
                            be_write <= Hwrite;
                            if (Hwrite) begin
                                state <= S_WDATA;
                            end else begin
                                state    <= S_BUSY;
                                be_valid <= 1'b1;
`ifdef AHB_SLV_TIMEOUT_EN
                                tmo_cnt  <= '0;
`endif
                            end
                        end
                    end
                end
                S_WDATA: begin
                    be_wdata <= Hwdata;
                    be_valid <= 1'b1;
                    state    <= S_BUSY;
`ifdef AHB_SLV_TIMEOUT_EN
                    tmo_cnt  <= '0;
`endif
                end
                // A completion in the final timeout cycle still wins
                S_BUSY: begin
                    if (be_done) begin
                        be_valid  <= 1'b0;
                        Hreadyout <= 1'b1;
                        state     <= S_IDLE;
                        if (!be_write) begin
                            Hrdata <= be_rdata;
                        end
`ifdef AHB_SLV_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        be_valid <= 1'b0;
                        Hresp    <= RESP_ERROR;
                        state    <= S_ERR1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                    end
                end
                S_ERR1: begin
                    Hreadyout <= 1'b1;
                    state     <= S_ERR2;
                end
                default: begin
                    state     <= S_IDLE;
                    Hreadyout <= 1'b1;
                    Hresp     <= RESP_OKAY;
                    be_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: pipelined AHB master, randomized back-end
// responder and a transfer-level reference model of wait states, decode and data.
module tb_ahb_slave_if;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SLOT = 32'h0400_0000;
    localparam logic [31:0] WIN  = 32'h0C00_0000;

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  sel;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } req_t;

    logic        Hclk;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        Hreadyout;
    logic        be_valid;
    logic        be_write;
    logic [31:0] be_addr;
    logic [31:0] be_wdata;
    logic [2:0]  be_sel;
    logic        be_done;
    logic [31:0] be_rdata;

    int total = 0;
    int bad   = 0;

    xfer_t       seq_q[$];
    req_t        req_q[$];
    logic [31:0] last_rd;

    bit          be_toggle;
    bit          be_hang;
    bit          rd_fix_en;
    int          be_fix_delay;
    logic [31:0] rd_fix;

    ahb_slave_if #(
        .BASE_ADDR(BASE)
`ifdef AHB_SLV_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Hrdata(Hrdata),
        .Hresp(Hresp), .Hreadyout(Hreadyout), .be_valid(be_valid),
        .be_write(be_write), .be_addr(be_addr), .be_wdata(be_wdata),
        .be_sel(be_sel), .be_done(be_done), .be_rdata(be_rdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // Back-end responder: records each request and completes it after a chosen delay
    initial begin : responder
        req_t cur;
        bit   pending;
        int   cnt;
        pending  = 1'b0;
        cnt      = 0;
        be_done  = 1'b0;
        be_rdata = '0;
        forever begin
            @(posedge Hclk); #1;
            be_done  = 1'b0;
            be_rdata = $urandom;
            if (be_toggle) begin
                be_done = 1'($urandom_range(0, 1));
            end else if (be_valid) begin
                if (!pending) begin
                    pending   = 1'b1;
                    cur.addr  = be_addr;
                    cur.write = be_write;
                    cur.sel   = be_sel;
                    cur.wdata = be_wdata;
                    cur.delay = (be_fix_delay >= 0) ? be_fix_delay : int'($urandom_range(0, 4));
                    cnt       = cur.delay;
                end
                if (!be_hang) begin
                    if (cnt == 0) begin
                        cur.rdata = rd_fix_en ? rd_fix : $urandom;
                        be_rdata  = cur.rdata;
                        be_done   = 1'b1;
                        req_q.push_back(cur);
                        pending   = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end else begin
                pending = 1'b0;
            end
        end
    end

    task automatic add(input logic [1:0] trans, input logic [31:0] addr,
                       input logic write, input logic [31:0] wdata);
        xfer_t x;
        x.trans = trans;
        x.addr  = addr;
        x.write = write;
        x.wdata = wdata;
        seq_q.push_back(x);
    endtask

    // Pipelined AHB master: drives seq_q and checks each data phase as it completes
    task automatic run_seq(input string tag, input bit rand_rdy);
        int          i = 0;
        int          cyc = 0;
        int          waits = 0;
        int          exp_waits;
        bit          dp_v = 1'b0;
        bit          rdy;
        xfer_t       dp;
        req_t        r;
        logic [1:0]  first_resp = 2'b00;
        logic [31:0] off;
        logic [2:0]  exp_sel;
        while ((i < seq_q.size() || dp_v) && cyc < 3000) begin
            Hreadyin = (dp_v || !rand_rdy) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            if (i < seq_q.size()) begin
                Htrans = seq_q[i].trans;
                Haddr  = seq_q[i].addr;
                Hwrite = seq_q[i].write;
            end else begin
                Htrans = 2'b00;
                Haddr  = $urandom;
                Hwrite = 1'($urandom_range(0, 1));
            end
            Hwdata = (dp_v && dp.write) ? dp.wdata : $urandom;
            rdy    = Hreadyout;
            if (dp_v && !rdy) begin
                if (waits == 0) first_resp = Hresp;
                waits++;
            end else if (dp_v) begin
                dp_v = 1'b0;
                off  = dp.addr - BASE;
                total++;
                if (dp.trans == 2'b00 || dp.trans == 2'b01) begin
                    if (waits != 0 || Hresp !== 2'b00) begin
                        bad++;
                        $display("FAIL %s idle_okay @%0h: waits=%0d resp=%0b want waits=0 resp=00",
                                 tag, dp.addr, waits, Hresp);
                    end
                end else if (off >= WIN) begin
                    if (waits != 1 || first_resp !== 2'b01 || Hresp !== 2'b01) begin
                        bad++;
                        $display("FAIL %s unmapped_err @%0h: waits=%0d resp=%0b,%0b want 1 01,01",
                                 tag, dp.addr, waits, first_resp, Hresp);
                    end
                end else if (req_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s no_request @%0h: got 0 requests want 1", tag, dp.addr);
                end else begin
                    r         = req_q.pop_front();
                    exp_sel   = 3'(1 << (off / SLOT));
                    exp_waits = (dp.write ? 1 : 0) + r.delay + 1;
                    if (r.addr !== dp.addr || r.write !== dp.write || r.sel !== exp_sel) begin
                        bad++;
                        $display("FAIL %s request: got a=%0h w=%0b s=%0b want a=%0h w=%0b s=%0b",
                                 tag, r.addr, r.write, r.sel, dp.addr, dp.write, exp_sel);
                    end
                    total++;
                    if (waits != exp_waits || Hresp !== 2'b00) begin
                        bad++;
                        $display("FAIL %s waits @%0h: got %0d resp=%0b want %0d resp=00",
                                 tag, dp.addr, waits, Hresp, exp_waits);
                    end
                    total++;
                    if (dp.write) begin
                        if (r.wdata !== dp.wdata || Hrdata !== last_rd) begin
                            bad++;
                            $display("FAIL %s write_data: got wd=%0h rd=%0h want wd=%0h rd=%0h",
                                     tag, r.wdata, Hrdata, dp.wdata, last_rd);
                        end
                    end else begin
                        if (Hrdata !== r.rdata) begin
                            bad++;
                            $display("FAIL %s read_data @%0h: got %0h want %0h",
                                     tag, dp.addr, Hrdata, r.rdata);
                        end
                        last_rd = r.rdata;
                    end
                end
            end
            if (Hreadyin && rdy && i < seq_q.size()) begin
                dp    = seq_q[i];
                dp_v  = 1'b1;
                waits = 0;
                i++;
            end
            @(posedge Hclk); #1;
            cyc++;
        end
        Htrans   = 2'b00;
        Hreadyin = 1'b1;
        total++;
        if (cyc >= 3000 || req_q.size() != 0) begin
            bad++;
            $display("FAIL %s end_state: cycles=%0d leftover_requests=%0d want <3000 and 0",
                     tag, cyc, req_q.size());
        end
        seq_q.delete();
        req_q.delete();
    endtask

    task automatic test_reset();
        Hresetn = 1'b0;
        be_toggle = 1'b1;
        repeat (2) begin @(posedge Hclk); #1; end
        total++;
        if (Hreadyout !== 1'b1 || Hresp !== 2'b00 || Hrdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_ahb: got rdy=%0b resp=%0b rd=%0h want 1 00 0", Hreadyout, Hresp, Hrdata);
        end
        total++;
        if (be_valid !== 1'b0 || be_write !== 1'b0 || be_addr !== 32'h0 ||
            be_wdata !== 32'h0 || be_sel !== 3'b000) begin
            bad++;
            $display("FAIL reset_be: got v=%0b w=%0b a=%0h d=%0h s=%0b want all zero",
                     be_valid, be_write, be_addr, be_wdata, be_sel);
        end
        be_toggle = 1'b0;
        Hresetn = 1'b1;
        last_rd = '0;
        @(posedge Hclk); #1;
    endtask

    task automatic test_single_write();
        be_fix_delay = 2;
        add(2'b10, 32'h8000_0000, 1'b1, 32'h0000_00A3);
        run_seq("single_write", 1'b0);
        be_fix_delay = -1;
    endtask

    task automatic test_single_read();
        rd_fix_en = 1'b1;
        rd_fix = 32'h0000_005A;
        add(2'b10, 32'h8400_00A2, 1'b0, 32'h0);
        run_seq("single_read", 1'b0);
        rd_fix_en = 1'b0;
    endtask

    task automatic test_burst();
        for (int k = 0; k < 4; k++) begin
            add(k == 0 ? 2'b10 : 2'b11, 32'h8800_0000 + 32'(k), 1'b1, $urandom);
        end
        run_seq("burst", 1'b0);
    endtask

    task automatic test_unmapped();
        add(2'b10, 32'h9000_0000, 1'b0, 32'h0);
        add(2'b10, 32'h8000_0040, 1'b0, 32'h0);
        add(2'b10, 32'h9000_0004, 1'b1, 32'h1234);
        add(2'b10, 32'h8400_0008, 1'b1, 32'h5678);
        run_seq("unmapped", 1'b0);
    endtask

    task automatic test_boundaries();
        add(2'b10, BASE + WIN - 32'h1, 1'b0, 32'h0);
        add(2'b10, BASE + WIN, 1'b0, 32'h0);
        add(2'b10, BASE - 32'h1, 1'b1, 32'hDEAD);
        add(2'b10, BASE + SLOT - 32'h1, 1'b1, $urandom);
        add(2'b10, BASE + SLOT, 1'b0, 32'h0);
        add(2'b10, BASE + 2 * SLOT, 1'b1, $urandom);
        add(2'b10, 32'hFFFF_FFFC, 1'b0, 32'h0);
        run_seq("boundary", 1'b0);
    endtask

    task automatic test_idle_busy();
        add(2'b00, BASE, 1'b1, 32'h0);
        add(2'b01, BASE + 32'h4, 1'b0, 32'h0);
        add(2'b10, BASE + 32'h8, 1'b0, 32'h0);
        add(2'b00, BASE + 32'hC, 1'b0, 32'h0);
        add(2'b10, BASE + SLOT, 1'b1, $urandom);
        add(2'b01, BASE + SLOT, 1'b1, 32'h0);
        run_seq("idle_busy", 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          t;
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 5))
                0:       a = BASE + WIN + $urandom_range(0, 32'h33FF_FFFF);
                1:       a = $urandom_range(0, 32'h7FFF_FFFF);
                default: a = BASE + $urandom_range(0, 2) * SLOT + $urandom_range(0, SLOT - 1);
            endcase
            t = $urandom_range(0, 9);
            add(t == 0 ? 2'b00 : (t == 1 ? 2'b01 : (t < 6 ? 2'b10 : 2'b11)),
                a, 1'($urandom_range(0, 1)), $urandom);
        end
        run_seq("random", 1'b1);
    endtask

    task automatic test_reset_mid();
        be_hang  = 1'b1;
        Hreadyin = 1'b1;
        Htrans   = 2'b10;
        Haddr    = 32'h8400_0010;
        Hwrite   = 1'b0;
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        @(posedge Hclk); #1;
        total++;
        if (be_valid !== 1'b1 || Hreadyout !== 1'b0) begin
            bad++;
            $display("FAIL mid_busy: got v=%0b rdy=%0b want 1 0", be_valid, Hreadyout);
        end
        Hresetn = 1'b0;
        @(posedge Hclk); #1;
        total++;
        if (be_valid !== 1'b0 || Hreadyout !== 1'b1 || be_addr !== 32'h0 ||
            be_sel !== 3'b000 || Hrdata !== 32'h0 || Hresp !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset: got v=%0b rdy=%0b a=%0h s=%0b rd=%0h resp=%0b want 0 1 0 0 0 00",
                     be_valid, Hreadyout, be_addr, be_sel, Hrdata, Hresp);
        end
        Hresetn = 1'b1;
        be_hang = 1'b0;
        last_rd = '0;
        @(posedge Hclk); #1;
        req_q.delete();
        add(2'b10, 32'h8800_0100, 1'b0, 32'h0);
        run_seq("after_reset", 1'b0);
    endtask

`ifdef AHB_SLV_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        be_hang = 1'b1;
        Htrans  = 2'b10;
        Haddr   = BASE + 32'h10;
        Hwrite  = 1'b0;
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        while (be_valid && n < 20) begin
            n++;
            @(posedge Hclk); #1;
        end
        total++;
        if (n != 4 || Hresp !== 2'b01 || Hreadyout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err1: got busy=%0d resp=%0b rdy=%0b want 4 01 0", n, Hresp, Hreadyout);
        end
        @(posedge Hclk); #1;
        total++;
        if (Hresp !== 2'b01 || Hreadyout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_err2: got resp=%0b rdy=%0b want 01 1", Hresp, Hreadyout);
        end
        be_hang = 1'b0;
        @(posedge Hclk); #1;
        req_q.delete();
    endtask
`endif

    initial begin
        Hresetn      = 1'b0;
        Hreadyin     = 1'b1;
        Htrans       = 2'b00;
        Haddr        = '0;
        Hwrite       = 1'b0;
        Hwdata       = '0;
        be_toggle    = 1'b0;
        be_hang      = 1'b0;
        rd_fix_en    = 1'b0;
        rd_fix       = '0;
        be_fix_delay = -1;
        last_rd      = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_burst();
        test_unmapped();
        test_boundaries();
        test_idle_busy();
        test_random();
        test_reset_mid();
`ifdef AHB_SLV_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
